// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package adder_sched_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Requester and result handshake bundle for adder_rr_scheduler.
interface adder_rr_scheduler_if
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();
  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic                        res_valid;
  logic                        res_ready;
  logic [WIDTH-1:0]            res_sum;
  logic                        res_carry;
  logic [IW-1:0]               res_id;
  logic [CNT_W-1:0]            op_count;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id, op_count
  );
endinterface

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above ptr, wrapping.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);
  logic          found;
  logic [IW-1:0] idx;

  // N_REQ is a power of two, so IW-bit addition wraps modulo N_REQ for free.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/adder_rr_scheduler.sv
// One registered adder shared by N_REQ requesters via round-robin, with a
// single-entry result register and a saturating consumed-op counter.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_rr_scheduler_if.slave   bus
);
  localparam int IW = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             consume, slot_free, accept;
  logic [WIDTH:0]   add_res;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A full slot being drained this cycle can take a new operand pair: no bubble.
  assign consume       = (state_q == FULL) && bus.res_ready;
  assign slot_free     = (state_q == EMPTY) || consume;
  assign bus.req_ready = (slot_free && !rst) ? grant : '0;
  assign accept        = |bus.req_ready;
  assign add_res       = {1'b0, bus.req_a[grant_idx]} + {1'b0, bus.req_b[grant_idx]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      ptr_d   = grant_idx + IW'(1);
      sum_d   = add_res[WIDTH-1:0];
      carry_d = add_res[WIDTH];
      id_d    = grant_idx;
    end else if (consume) begin
      state_d = EMPTY;
    end
    if (consume && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_carry = carry_q;
  assign bus.res_id    = id_q;
  assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed + randomized bench for adder_rr_scheduler against a transaction-level model.
module tb_adder_rr_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 16;

  logic clk = 1'b0;
  logic rst, rst_s;
  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .CNT_W(C)) bus  ();
  adder_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .CNT_W(4)) sbus ();

  adder_rr_scheduler #(.N_REQ(N), .WIDTH(W), .CNT_W(C)) u_dut (
    .clk (clk), .rst (rst),   .bus (bus.slave));
  adder_rr_scheduler #(.N_REQ(N), .WIDTH(W), .CNT_W(4)) u_sat (
    .clk (clk), .rst (rst_s), .bus (sbus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the result slot as a plain record plus the priority pointer.
  bit         m_valid;
  logic [7:0] m_sum;
  bit         m_carry;
  int         m_id, m_cnt, m_ptr, last_grant;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are already driven (posedge+1). Check grant, advance model, check result.
  task automatic cycle();
    int g, s;
    bit free;
    logic [N-1:0] exp_rdy, one;
    one = 1;
    #1;
    free = !m_valid || bus.res_ready;
    g = -1;
    if (!rst && free)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    exp_rdy = (g >= 0) ? (one << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    last_grant = g;
    if (rst) begin
      m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      if (m_valid && bus.res_ready && m_cnt < (1 << C) - 1) m_cnt++;
      if (g >= 0) begin
        s       = int'(bus.req_a[g]) + int'(bus.req_b[g]);
        m_sum   = s[7:0];
        m_carry = (s >= 256);
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % N;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk); #1;
    chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
    chk("res_sum",   64'(bus.res_sum),   64'(m_sum));
    chk("res_carry", 64'(bus.res_carry), 64'(m_carry));
    chk("res_id",    64'(bus.res_id),    64'(m_id));
    chk("op_count",  64'(bus.op_count),  64'(m_cnt));
  endtask

  bit pend [N];
  int s_cnt;
  bit s_valid, s_cons;

  initial begin
    rst = 1; rst_s = 1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 0;
    sbus.req_valid = '0; sbus.req_a = '0; sbus.req_b = '0; sbus.res_ready = 0;
    m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;

    // single request
    bus.req_valid = 4'b0001; bus.req_a[0] = 8'h12; bus.req_b[0] = 8'h34; bus.res_ready = 1;
    cycle();
    chk("t1_rdy_grant", 64'(last_grant), 64'(0));
    chk("t1_sum", 64'(bus.res_sum), 64'h46);
    chk("t1_carry", 64'(bus.res_carry), 64'(0));
    bus.req_valid = '0;
    cycle();

    // overflow
    bus.req_valid = 4'b0100; bus.req_a[2] = 8'hFF; bus.req_b[2] = 8'h01;
    cycle();
    chk("t2_sum", 64'(bus.res_sum), 64'h00);
    chk("t2_carry", 64'(bus.res_carry), 64'(1));
    chk("t2_id", 64'(bus.res_id), 64'(2));
    bus.req_valid = '0;
    cycle();

    // fairness from a fresh pointer
    rst = 1; cycle(); rst = 0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = 8'($urandom); bus.req_b[i] = 8'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t3_grant", 64'(last_grant), 64'(k % 4));
      if (last_grant >= 0) begin
        bus.req_a[last_grant] = 8'($urandom); bus.req_b[last_grant] = 8'($urandom);
      end
    end
    bus.req_valid = '0;
    cycle();
    chk("t3_count", 64'(bus.op_count), 64'd8);

    // backpressure
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = 4'b0010; bus.res_ready = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_hold_rdy", 64'(bus.req_ready), 64'(0));
      chk("t4_hold_id", 64'(bus.res_id), 64'(0));
    end
    bus.res_ready = 1;
    cycle();
    chk("t4_grant", 64'(last_grant), 64'(1));
    chk("t4_id", 64'(bus.res_id), 64'(1));
    bus.req_valid = '0;
    cycle();

    // reset mid-operation
    bus.req_valid = 4'b1000;
    cycle();
    bus.req_valid = '0; rst = 1;
    cycle();
    chk("t5_valid", 64'(bus.res_valid), 64'(0));
    chk("t5_count", 64'(bus.op_count), 64'(0));
    rst = 0; bus.req_valid = 4'b1111;
    cycle();
    chk("t5_grant", 64'(last_grant), 64'(0));
    bus.req_valid = '0;
    cycle();

    // randomized traffic honoring hold-until-ready
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          bus.req_a[i] = 8'($urandom); bus.req_b[i] = 8'($urandom);
        end
      for (int i = 0; i < N; i++) bus.req_valid[i] = pend[i];
      bus.res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      if (last_grant >= 0) pend[last_grant] = 0;
    end
    rst = 0; bus.req_valid = '0;

    // saturation on the narrow-counter instance
    rst_s = 1; @(posedge clk); #1;
    rst_s = 0; sbus.req_valid = 4'b0001; sbus.res_ready = 1;
    s_cnt = 0; s_valid = 0;
    for (int k = 0; k < 22; k++) begin
      #1;
      s_cons = s_valid && sbus.res_ready;
      @(posedge clk); #1;
      if (s_cons && s_cnt < 15) s_cnt++;
      s_valid = 1;
      chk("t6_cnt", 64'(sbus.op_count), 64'(s_cnt));
    end
    chk("t6_sat", 64'(sbus.op_count), 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
